edge_event_capture: RTL and testbench



---
 rtl/edge_event_capture.sv | 128 ++++++++++++
 tb/tb_edge_event_capture.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_capture.sv
// edge_event_capture: synchronises an asynchronous level, detects its edges
// and queues timestamped edge records in a show-ahead FIFO.
//
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   i1               asynchronous level input
//   clr              synchronous soft clear (FIFO, o_ovf, timestamp)
//   o_valid/o_ready  head-record handshake (pop on o_valid & o_ready)
//   o_edge, o_ts     head record: 1 = rising, 0 = falling; timestamp
//   o_count          records held
//   o_ovf            sticky: an event was dropped on a full FIFO
// Option: EDGE_CAPTURE_GLITCH_FILTER_EN adds a third sync flop and
// requires two equal synchronised samples before an edge is accepted.
module edge_event_capture #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i1,
  input  logic                   clr,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   o_edge,
  output logic [TS_W-1:0]        o_ts,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_ovf
);
  localparam int AW = $clog2(DEPTH);

  logic s1_q, s2_q;
`ifdef EDGE_CAPTURE_GLITCH_FILTER_EN
  logic s3_q;
`endif
  logic            lvl_q, lvl_d;
  logic [1:0]      arm_q, arm_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [AW:0]     wr_q, wr_d;
  logic [AW:0]     rd_q, rd_d;
  logic            ovf_q, ovf_d;
  logic            edge_mem_q [DEPTH];
  logic [TS_W-1:0] ts_mem_q [DEPTH];

  logic armed, det, empty, full, pop, push, drop;

  assign armed = arm_q[1];

`ifdef EDGE_CAPTURE_GLITCH_FILTER_EN
  assign det = armed & (s2_q == s3_q) & (s2_q != lvl_q);
`else
  assign det = armed & (s2_q != lvl_q);
`endif

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = ~empty & o_ready;
  assign push  = det & ~clr & (~full | pop);
  assign drop  = det & ~clr & full & ~pop;

  always_comb begin
    arm_d = armed ? arm_q : arm_q + 2'd1;
    // While unarmed, follow the value s2 is about to take so the
    // level present at reset release is absorbed, not reported.
    lvl_d = lvl_q;
    if (!armed) begin
      lvl_d = s1_q;
    end else if (det) begin
      lvl_d = s2_q;
    end
    ts_d  = clr ? '0 : ts_q + TS_W'(1);
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = 1'b0;
    end else begin
      if (pop)  rd_d = rd_q + (AW+1)'(1);
      if (push) wr_d = wr_q + (AW+1)'(1);
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
`ifdef EDGE_CAPTURE_GLITCH_FILTER_EN
      s3_q  <= 1'b0;
`endif
      lvl_q <= 1'b0;
      arm_q <= 2'd0;
      ts_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      s1_q  <= i1;
      s2_q  <= s1_q;
`ifdef EDGE_CAPTURE_GLITCH_FILTER_EN
      s3_q  <= s2_q;
`endif
      lvl_q <= lvl_d;
      arm_q <= arm_d;
      ts_q  <= ts_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  // Record storage needs no reset: outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      edge_mem_q[wr_q[AW-1:0]] <= s2_q;
      ts_mem_q[wr_q[AW-1:0]]   <= ts_q;
    end
  end

  assign o_valid = ~empty;
  assign o_count = wr_q - rd_q;
  assign o_ovf   = ovf_q;
  assign o_edge  = ~empty & edge_mem_q[rd_q[AW-1:0]];
  assign o_ts    = empty ? '0 : ts_mem_q[rd_q[AW-1:0]];

endmodule

// File: tb/tb_edge_event_capture.sv
// Testbench for edge_event_capture: directed scenarios plus random
// stimulus, checked against a queue-based reference model.
module tb_edge_event_capture;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i1 = 1'b0;
  logic       clr = 1'b0;
  logic       o_ready = 1'b0;
  logic       o_valid, o_edge, o_ovf;
  logic [7:0] o_ts;
  logic [2:0] o_count;

  edge_event_capture #(.TS_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i1(i1), .clr(clr),
    .o_valid(o_valid), .o_ready(o_ready), .o_edge(o_edge),
    .o_ts(o_ts), .o_count(o_count), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  wire [13:0] got = {o_valid, o_count, o_ovf, o_edge, o_ts};

  typedef struct {
    logic       e;
    logic [7:0] t;
  } rec_t;

  rec_t       mq[$];
  logic       hist[$];
  logic       movf;
  logic       mlvl;
  logic [7:0] mts;
  int         medge;

  function automatic logic [13:0] expv();
    if (mq.size() == 0) return {1'b0, 3'd0, movf, 1'b0, 8'd0};
    return {1'b1, 3'(mq.size()), movf, mq[0].e, mq[0].t};
  endfunction

  task automatic model_reset();
    mq.delete();
    hist.delete();
    hist.push_back(1'b0);
    movf = 1'b0;
    mlvl = 1'b0;
    mts = 8'd0;
    medge = 0;
  endtask

  // Events are level changes in the stream of clock-sampled i1 values,
  // seen two samples late; the first two samples after release are
  // absorbed as the initial level.
  task automatic model_step();
    logic ev;
    logic pp;
    if (!rst_n) begin
      model_reset();
      return;
    end
    medge++;
    hist.push_back(i1);
    if (hist.size() > 6) hist.delete(0);
    ev = 1'b0;
    if (medge == 2) begin
      mlvl = hist[$-1];
    end else if (medge >= 3) begin
`ifdef EDGE_CAPTURE_GLITCH_FILTER_EN
      if (hist[$-2] == hist[$-3] && hist[$-2] != mlvl) begin
`else
      if (hist[$-2] != mlvl) begin
`endif
        ev = 1'b1;
        mlvl = hist[$-2];
      end
    end
    pp = (mq.size() > 0) && o_ready;
    if (clr) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      if (pp) mq.delete(0);
      if (ev) begin
        if (mq.size() < 4) mq.push_back('{e: mlvl, t: mts});
        else movf = 1'b1;
      end
    end
    mts = clr ? 8'd0 : mts + 8'd1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i1 = 1'b1;
    tick(3);
    compared++;
    if (got !== 14'd0) begin
      mismatched++;
      $display("FAIL reset_hold: got %h expected %h", got, 14'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      compared++;
      if (got !== expv()) begin
        mismatched++;
        $display("FAIL reset_arm: got %h expected %h", got, expv());
      end
    end
    compared++;
    if ({o_valid, o_count, o_ovf} !== 5'd0) begin
      mismatched++;
      $display("FAIL reset_no_event: got %b expected 00000",
               {o_valid, o_count, o_ovf});
    end
  endtask

  task automatic test_single();
    int lat;
    o_ready = 1'b1;
    i1 = 1'b0;
    tick(6);
    o_ready = 1'b0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(4);
    i1 = 1'b1;
    lat = 0;
    while (!o_valid && lat < 10) begin
      tick(1);
      lat++;
      compared++;
      if (got !== expv()) begin
        mismatched++;
        $display("FAIL single_model: got %h expected %h", got, expv());
      end
    end
    compared++;
    if (lat != 3) begin
      mismatched++;
      $display("FAIL single_latency: got %0d expected 3", lat);
    end
    compared++;
    if ({o_edge, o_ts} !== {1'b1, 8'd6}) begin
      mismatched++;
      $display("FAIL single_rise: got %b/%0d expected 1/6", o_edge, o_ts);
    end
    tick(7);
    i1 = 1'b0;
    tick(6);
    compared++;
    if (o_count !== 3'd2 || got !== expv()) begin
      mismatched++;
      $display("FAIL single_count2: got %h expected %h", got, expv());
    end
    o_ready = 1'b1;
    tick(1);
    compared++;
    if ({o_count, o_edge, o_ts} !== {3'd1, 1'b0, 8'd16}) begin
      mismatched++;
      $display("FAIL single_fall: got %0d/%b/%0d expected 1/0/16",
               o_count, o_edge, o_ts);
    end
    tick(1);
    o_ready = 1'b0;
    compared++;
    if (o_count !== 3'd0 || o_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL single_drain: got count %0d expected 0", o_count);
    end
  endtask

  task automatic test_overflow();
    logic first;
    o_ready = 1'b0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    first = ~i1;
    for (int k = 0; k < 6; k++) begin
      i1 = ~i1;
      for (int j = 0; j < 3; j++) begin
        tick(1);
        compared++;
        if (got !== expv()) begin
          mismatched++;
          $display("FAIL ovf_model: got %h expected %h", got, expv());
        end
      end
    end
    tick(3);
    compared++;
    if ({o_count, o_ovf, o_edge} !== {3'd4, 1'b1, first}) begin
      mismatched++;
      $display("FAIL ovf_full: got %0d/%b/%b expected 4/1/%b",
               o_count, o_ovf, o_edge, first);
    end
    i1 = ~i1;
    tick(2);
    o_ready = 1'b1;
    tick(1);
    o_ready = 1'b0;
    compared++;
    if (o_count !== 3'd4 || got !== expv()) begin
      mismatched++;
      $display("FAIL ovf_push_pop: got %h expected %h", got, expv());
    end
  endtask

  task automatic test_wrap();
    logic v;
    o_ready = 1'b0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(252);
    v = i1;
    i1 = ~v;
    tick(1);
    i1 = v;
    tick(1);
    i1 = ~v;
    tick(4);
    compared++;
    if ({o_count, o_edge, o_ts} !== {3'd3, ~v, 8'd254}) begin
      mismatched++;
      $display("FAIL wrap_first: got %0d/%b/%0d expected 3/%b/254",
               o_count, o_edge, o_ts, ~v);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      compared++;
      if ({o_edge, o_ts} !== {~v, 8'd254} || got !== expv()) begin
        mismatched++;
        $display("FAIL wrap_hold: got %h expected %h", got, expv());
      end
    end
    o_ready = 1'b1;
    tick(1);
    o_ready = 1'b0;
    compared++;
    if ({o_edge, o_ts} !== {v, 8'd255}) begin
      mismatched++;
      $display("FAIL wrap_255: got %b/%0d expected %b/255", o_edge, o_ts, v);
    end
    o_ready = 1'b1;
    tick(1);
    o_ready = 1'b0;
    compared++;
    if ({o_edge, o_ts} !== {~v, 8'd0}) begin
      mismatched++;
      $display("FAIL wrap_0: got %b/%0d expected %b/0", o_edge, o_ts, ~v);
    end
  endtask

  task automatic test_clr();
    o_ready = 1'b0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i1 = ~i1;
      tick(3);
    end
    compared++;
    if ({o_count, o_ovf} !== {3'd4, 1'b1} || got !== expv()) begin
      mismatched++;
      $display("FAIL clr_setup: got %h expected %h", got, expv());
    end
    i1 = ~i1;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    compared++;
    if ({o_valid, o_count, o_ovf} !== 5'd0) begin
      mismatched++;
      $display("FAIL clr_empty: got %b expected 00000",
               {o_valid, o_count, o_ovf});
    end
    tick(4);
    compared++;
    if (o_count !== 3'd0 || got !== expv()) begin
      mismatched++;
      $display("FAIL clr_edge_dropped: got %h expected %h", got, expv());
    end
    i1 = ~i1;
    tick(3);
    compared++;
    if ({o_count, o_ts} !== {3'd1, 8'd6}) begin
      mismatched++;
      $display("FAIL clr_ts_restart: got %0d/%0d expected 1/6",
               o_count, o_ts);
    end
  endtask

`ifdef EDGE_CAPTURE_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic [7:0] k;
    o_ready = 1'b0;
    i1 = 1'b0;
    tick(6);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    i1 = 1'b1;
    tick(1);
    i1 = 1'b0;
    tick(6);
    compared++;
    if (o_count !== 3'd0 || got !== expv()) begin
      mismatched++;
      $display("FAIL glitch_short: got %h expected %h", got, expv());
    end
    k = mts;
    i1 = 1'b1;
    tick(3);
    i1 = 1'b0;
    tick(8);
    compared++;
    if ({o_count, o_edge, o_ts} !== {3'd2, 1'b1, k + 8'd3}) begin
      mismatched++;
      $display("FAIL glitch_rise: got %0d/%b/%0d expected 2/1/%0d",
               o_count, o_edge, o_ts, k + 8'd3);
    end
    o_ready = 1'b1;
    tick(1);
    o_ready = 1'b0;
    compared++;
    if ({o_edge, o_ts} !== {1'b0, k + 8'd6}) begin
      mismatched++;
      $display("FAIL glitch_fall: got %b/%0d expected 0/%0d",
               o_edge, o_ts, k + 8'd6);
    end
  endtask
`endif

  task automatic test_reset_mid();
    o_ready = 1'b0;
    i1 = ~i1;
    tick(3);
    i1 = ~i1;
    tick(4);
    compared++;
    if (o_valid !== 1'b1 || got !== expv()) begin
      mismatched++;
      $display("FAIL mid_setup: got %h expected %h", got, expv());
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compared++;
    if (got !== 14'd0) begin
      mismatched++;
      $display("FAIL mid_reset_async: got %h expected 0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      compared++;
      if (got !== expv()) begin
        mismatched++;
        $display("FAIL mid_after: got %h expected %h", got, expv());
      end
    end
  endtask

  task automatic test_random();
    int pct;
    pct = 50;
    for (int c = 0; c < 2000; c++) begin
      tick(1);
      compared++;
      if (got !== expv()) begin
        mismatched++;
        $display("FAIL random c=%0d: got %h expected %h", c, got, expv());
      end
      if (c % 250 == 0) pct = int'($urandom_range(0, 100));
      if ($urandom_range(0, 3) == 0) i1 = ~i1;
      o_ready = ($urandom_range(0, 99) < pct);
      clr = ($urandom_range(0, 199) == 0);
    end
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
`ifdef EDGE_CAPTURE_GLITCH_FILTER_EN
    test_glitch();
`else
    test_single();
    test_overflow();
    test_wrap();
    test_clr();
`endif
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
